// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg
//   Shared definitions for the fetch queue unit, its prefetch FIFO and the bench.
//   - NOP_INSTR       : instruction word placed in IF/ID when it holds no instruction
//   - PC_INC_DEFAULT  : default byte increment between sequential instructions
//   - PC_FIELD_W /
//     INSTR_FIELD_W   : default widths of the two fields of a queue entry
//   - entry_width()   : width of one queue entry {pc, instr}
package fetch_queue_unit_pkg;

   localparam int unsigned NOP_INSTR      = 0;
   localparam int unsigned PC_INC_DEFAULT = 4;
   localparam int unsigned PC_FIELD_W     = 32;
   localparam int unsigned INSTR_FIELD_W  = 32;

   function automatic int unsigned entry_width(input int unsigned pc_w,
                                               input int unsigned instr_w);
      return pc_w + instr_w;
   endfunction

endpackage

// File: rtl/fetch_queue_unit_queue.sv
// fetch_queue
//   Synchronous FIFO with circular read/write pointers and an occupancy count.
//   Push and pop in the same cycle are accepted even when full; pop while
//   empty is ignored. i_clear empties the FIFO and overrides push/pop.
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_clear        : drop all entries at the next edge
//   i_push, i_data : write one entry
//   i_pop          : remove the head entry
//   o_data         : head entry (meaningful only when !o_empty)
//   o_empty        : no entries stored
//   o_count        : number of entries stored (0..DEPTH)
module fetch_queue
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned WIDTH = entry_width(PC_FIELD_W, INSTR_FIELD_W),
   parameter int unsigned DEPTH = 4
)(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop  = i_pop & (count_q != '0);
      // a full FIFO still accepts a push when the head leaves in the same cycle
      do_push = i_push & ((count_q != FULL_CNT) | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: nothing is read until count says it was written
   always_ff @(posedge i_clk) begin
      if (do_push && !i_clear) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_empty = (count_q == '0);
   assign o_count = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Fetch stage that decouples PC generation from a variable-latency,
//   in-order instruction memory. Requests are credit-limited so that queued
//   plus outstanding instructions never exceed QUEUE_DEPTH; responses still
//   in flight when a redirect occurs are counted and discarded on arrival.
// Ports:
//   i_clk, i_rst_n            : clock (rising edge), asynchronous active-low reset
//   i_brq_addr, i_ctr_beq     : branch target / branch taken (redirect)
//   i_jmp_addr, i_ctr_jmp     : jump target / jump (redirect, wins over branch)
//   i_ctr_flush               : invalidate the IF/ID register
//   i_pc_we                   : 0 freezes the PC and blocks new requests
//   i_if_id_we                : 0 holds the IF/ID register
//   o_imem_req, o_imem_addr   : memory request valid / address
//   i_imem_valid, i_imem_instr: memory response valid / data (always accepted)
//   o_if_id_pc/instr/valid    : IF/ID register (pc is instruction address + PC_INC)
//   o_queue_count             : entries held in the prefetch queue
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned         NB_BITS     = PC_FIELD_W,
   parameter int unsigned         QUEUE_DEPTH = 4,
   parameter logic [NB_BITS-1:0]  RESET_PC    = '0,
   parameter int unsigned         PC_INC      = PC_INC_DEFAULT
)(
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [NB_BITS-1:0]            i_brq_addr,
   input  logic [NB_BITS-1:0]            i_jmp_addr,
   input  logic                          i_ctr_beq,
   input  logic                          i_ctr_jmp,
   input  logic                          i_ctr_flush,
   input  logic                          i_pc_we,
   input  logic                          i_if_id_we,
   output logic                          o_imem_req,
   output logic [NB_BITS-1:0]            o_imem_addr,
   input  logic                          i_imem_valid,
   input  logic [NB_BITS-1:0]            i_imem_instr,
   output logic [NB_BITS-1:0]            o_if_id_pc,
   output logic [NB_BITS-1:0]            o_if_id_instr,
   output logic                          o_if_id_valid,
   output logic [$clog2(QUEUE_DEPTH):0]  o_queue_count
);

   localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
   localparam int unsigned ENTRY_W = entry_width(NB_BITS, NB_BITS);
   localparam logic [NB_BITS-1:0] INC     = NB_BITS'(PC_INC);
   localparam logic [NB_BITS-1:0] NOP     = NB_BITS'(NOP_INSTR);
   localparam logic [CNT_W:0]     DEPTH_C = (CNT_W + 1)'(QUEUE_DEPTH);

   logic [NB_BITS-1:0] pc_q,       pc_d;
   logic [NB_BITS-1:0] resp_pc_q,  resp_pc_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic [CNT_W-1:0]   drop_q,     drop_d;
   logic [NB_BITS-1:0] id_pc_q,    id_pc_d;
   logic [NB_BITS-1:0] id_instr_q, id_instr_d;
   logic               id_valid_q, id_valid_d;

   logic               redirect;
   logic [NB_BITS-1:0] target;
   logic               issue;
   logic               push, pop;
   logic [CNT_W-1:0]   q_count;
   logic               q_empty;
   logic [ENTRY_W-1:0] q_head;
   logic [NB_BITS-1:0] head_pc, head_instr;

   always_comb begin
      redirect = i_ctr_jmp | i_ctr_beq;
      target   = i_ctr_jmp ? i_jmp_addr : i_brq_addr;
      // requests stay quiet while reset is held, even with i_pc_we high
      issue    = i_rst_n & i_pc_we & ~redirect &
                 (({1'b0, q_count} + {1'b0, inflight_q}) < DEPTH_C);
      push     = i_imem_valid & ~redirect & (drop_q == '0);
      pop      = ~i_ctr_flush & i_if_id_we & ~q_empty;
      head_pc    = q_head[ENTRY_W-1 -: NB_BITS];
      head_instr = q_head[NB_BITS-1:0];
   end

   always_comb begin
      pc_d       = pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(i_imem_valid);
      if (redirect) begin
         pc_d      = target;
         resp_pc_d = target;
         // every request still outstanding after this edge is stale
         drop_d    = inflight_q - CNT_W'(i_imem_valid);
      end else begin
         if (issue) pc_d = pc_q + INC;
         if (push)  resp_pc_d = resp_pc_q + INC;
         if (i_imem_valid && drop_q != '0) drop_d = drop_q - 1'b1;
      end
   end

   always_comb begin
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      if (i_ctr_flush) begin
         id_instr_d = NOP;
         id_valid_d = 1'b0;
      end else if (i_if_id_we) begin
         if (!q_empty) begin
            id_pc_d    = head_pc + INC;
            id_instr_d = head_instr;
            id_valid_d = 1'b1;
         end else begin
            id_instr_d = NOP;
            id_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q       <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         id_pc_q    <= '0;
         id_instr_q <= NOP;
         id_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
      end
   end

   fetch_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (redirect),
      .i_push  (push),
      .i_data  ({resp_pc_q, i_imem_instr}),
      .i_pop   (pop),
      .o_data  (q_head),
      .o_empty (q_empty),
      .o_count (q_count)
   );

   assign o_imem_req    = issue;
   assign o_imem_addr   = pc_q;
   assign o_if_id_pc    = id_pc_q;
   assign o_if_id_instr = id_instr_q;
   assign o_if_id_valid = id_valid_q;
   assign o_queue_count = q_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: in-order memory with adjustable latency,
// a queue-based reference model of the fetch stage, directed scenarios and
// a randomized phase.
module tb_fetch_queue_unit;
   import fetch_queue_unit_pkg::*;

   localparam int unsigned D = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] brq_addr, jmp_addr;
   logic        beq, jmp, flush, pc_we, ifwe;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_instr;
   logic [31:0] id_pc, id_instr;
   logic        id_valid;
   logic [2:0]  q_count;

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .NB_BITS     (32),
      .QUEUE_DEPTH (D),
      .RESET_PC    (32'h0),
      .PC_INC      (PC_INC_DEFAULT)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_brq_addr    (brq_addr),
      .i_jmp_addr    (jmp_addr),
      .i_ctr_beq     (beq),
      .i_ctr_jmp     (jmp),
      .i_ctr_flush   (flush),
      .i_pc_we       (pc_we),
      .i_if_id_we    (ifwe),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_valid  (imem_valid),
      .i_imem_instr  (imem_instr),
      .o_if_id_pc    (id_pc),
      .o_if_id_instr (id_instr),
      .o_if_id_valid (id_valid),
      .o_queue_count (q_count)
   );

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc, m_rpc, m_idpc, m_idinstr;
   bit          m_idv;
   int          m_infl, m_drop;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000 + (a >> 2);
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_pc = '0; m_rpc = '0; m_idpc = '0; m_idinstr = '0; m_idv = 1'b0;
      m_infl = 0; m_drop = 0;
   endfunction

   function automatic bit exp_req();
      return rst_n && pc_we && !(jmp || beq) && (mq.size() + m_infl < D);
   endfunction

   function automatic void model_edge();
      bit          redir = jmp || beq;
      logic [31:0] tgt   = jmp ? jmp_addr : brq_addr;
      bit          iss   = exp_req();
      ent_t        h;
      if (!rst_n) begin model_reset(); return; end
      if (flush) begin
         m_idv = 1'b0; m_idinstr = '0;
      end else if (ifwe) begin
         if (mq.size() > 0) begin
            h = mq.pop_front();
            m_idpc = h.pc + 32'd4; m_idinstr = h.instr; m_idv = 1'b1;
         end else begin
            m_idv = 1'b0; m_idinstr = '0;
         end
      end
      if (redir) begin
         m_drop = m_infl - int'(imem_valid);
         m_infl = m_infl - int'(imem_valid);
         mq.delete();
         m_pc = tgt; m_rpc = tgt;
      end else begin
         if (imem_valid) begin
            if (m_drop > 0) m_drop--;
            else begin
               mq.push_back('{m_rpc, imem_instr});
               m_rpc = m_rpc + 32'd4;
            end
         end
         m_infl = m_infl + int'(iss) - int'(imem_valid);
         if (iss) m_pc = m_pc + 32'd4;
      end
   endfunction

   // ---------------- memory model ----------------
   typedef struct { logic [31:0] addr; int due; } req_t;
   req_t        pend[$];
   int          lat = 1;
   bit          gappy = 1'b0;
   int          edge_cnt = 0;
   logic        req_s;
   logic [31:0] addr_s;

   task automatic mem_drive();
      imem_valid = 1'b0;
      imem_instr = '0;
      if (rst_n && pend.size() > 0 && pend[0].due <= edge_cnt + 1 &&
          (!gappy || $urandom_range(3) != 0)) begin
         imem_valid = 1'b1;
         imem_instr = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end
   endtask

   task automatic compare_all();
      chk("imem_req",      {31'b0, imem_req}, {31'b0, exp_req()});
      chk("imem_addr",     imem_addr, m_pc);
      chk("queue_count",   {29'b0, q_count}, mq.size());
      chk("if_id_valid",   {31'b0, id_valid}, {31'b0, m_idv});
      chk("if_id_instr",   id_instr, m_idinstr);
      chk("if_id_pc",      id_pc, m_idpc);
   endtask

   // one clock: check at negedge, advance model/memory at posedge, drive at +1
   task automatic cycle();
      @(negedge clk);
      compare_all();
      req_s  = imem_req;
      addr_s = imem_addr;
      @(posedge clk);
      edge_cnt++;
      model_edge();
      if (!rst_n) pend.delete();
      else if (req_s) pend.push_back('{addr_s, edge_cnt + lat});
      #1;
      mem_drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic expect_next_valid(input string name, input int budget,
                                    input logic [31:0] ei, input logic [31:0] ep);
      for (int i = 0; i < budget && !id_valid; i++) cycle();
      chk({name, "_valid"}, {31'b0, id_valid}, 32'd1);
      chk({name, "_instr"}, id_instr, ei);
      chk({name, "_pc"},    id_pc,    ep);
   endtask

   task automatic redirect_cycle(input bit j, input logic [31:0] ja,
                                 input bit b, input logic [31:0] ba, input bit f);
      jmp = j; jmp_addr = ja; beq = b; brq_addr = ba; flush = f;
      cycle();
      jmp = 1'b0; beq = 1'b0; flush = 1'b0;
   endtask

   logic [31:0] held_pc;

   initial begin
      rst_n = 1'b0; pc_we = 1'b1; ifwe = 1'b1;
      beq = 1'b0; jmp = 1'b0; flush = 1'b0;
      brq_addr = '0; jmp_addr = '0; imem_valid = 1'b0; imem_instr = '0;
      model_reset();
      #1;
      chk("reset_req",   {31'b0, imem_req}, 32'd0);
      chk("reset_addr",  imem_addr, 32'd0);
      chk("reset_valid", {31'b0, id_valid}, 32'd0);
      chk("reset_count", {29'b0, q_count}, 32'd0);
      run(2);
      rst_n = 1'b1;

      // 1. streaming
      run(3);
      chk("s1_first_valid", {31'b0, id_valid}, 32'd1);
      chk("s1_first_instr", id_instr, 32'h1000);
      chk("s1_first_pc",    id_pc,    32'd4);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         chk("s1_stream_instr", id_instr, 32'h1000 + k);
         chk("s1_stream_pc",    id_pc,    32'(4 * (k + 1)));
      end

      // 2. consumer stall fills the queue
      ifwe = 1'b0;
      run(6);
      chk("s2_full_count", {29'b0, q_count}, 32'd4);
      chk("s2_req_off",    {31'b0, imem_req}, 32'd0);
      ifwe = 1'b1;
      run(10);

      // 3. branch with flush, latency 3
      lat = 3;
      run(6);
      redirect_cycle(1'b0, 32'd0, 1'b1, 32'd40, 1'b1);
      chk("s3_flush_valid", {31'b0, id_valid}, 32'd0);
      expect_next_valid("s3_target", 20, 32'h100A, 32'd44);
      run(4);

      // 4. jump wins over branch
      lat = 1;
      redirect_cycle(1'b1, 32'd100, 1'b1, 32'd40, 1'b1);
      chk("s4_addr", imem_addr, 32'd100);
      expect_next_valid("s4_target", 20, 32'h1019, 32'd104);
      run(4);

      // 5. freeze with a flush inside the window
      held_pc = m_pc;
      pc_we = 1'b0; ifwe = 1'b0;
      cycle();
      flush = 1'b1; cycle(); flush = 1'b0;
      chk("s5_flush_valid", {31'b0, id_valid}, 32'd0);
      run(2);
      chk("s5_req_off", {31'b0, imem_req}, 32'd0);
      chk("s5_held_pc", imem_addr, held_pc);
      pc_we = 1'b1; ifwe = 1'b1;
      run(10);

      // 6. asynchronous reset with requests outstanding
      lat = 3;
      run(4);
      #3;
      rst_n = 1'b0;
      #1;
      chk("s6_req",   {31'b0, imem_req}, 32'd0);
      chk("s6_addr",  imem_addr, 32'd0);
      chk("s6_valid", {31'b0, id_valid}, 32'd0);
      chk("s6_instr", id_instr, 32'd0);
      chk("s6_pc",    id_pc, 32'd0);
      chk("s6_count", {29'b0, q_count}, 32'd0);
      model_reset(); pend.delete(); imem_valid = 1'b0; imem_instr = '0;
      run(2);
      rst_n = 1'b1;
      #1;
      chk("s6_first_addr", imem_addr, 32'd0);
      expect_next_valid("s6_restart", 20, 32'h1000, 32'd4);

      // randomized phase
      gappy = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) lat = $urandom_range(1, 4);
         pc_we = ($urandom_range(99) < 85);
         ifwe  = ($urandom_range(99) < 70);
         flush = ($urandom_range(99) < 5);
         beq   = ($urandom_range(99) < 5);
         jmp   = ($urandom_range(99) < 4);
         brq_addr = 32'($urandom_range(255)) << 2;
         jmp_addr = 32'($urandom_range(255)) << 2;
         cycle();
      end
      beq = 1'b0; jmp = 1'b0; flush = 1'b0;
      run(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
